// File: rtl/aclk_pkg.sv
// Shared types and constants for the alarm-clock time path: BCD digit type,
// time limits, per-cycle update selection and load-range helpers.
package aclk_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t MAX_DIGIT    = 4'd9;
  localparam digit_t MAX_MIN_TENS = 4'd5;
  localparam digit_t MAX_HR_TENS  = 4'd2;
  localparam digit_t MAX_HR_UNITS_AT_20 = 4'd3;
  localparam int unsigned MAX_HOUR = 23;

  typedef struct packed {
    digit_t ms_hr;
    digit_t ls_hr;
    digit_t ms_min;
    digit_t ls_min;
  } bcd_time_t;

  localparam bcd_time_t MIDNIGHT = '0;

  typedef enum logic [1:0] {
    UPD_IDLE,
    UPD_LOAD,
    UPD_REJECT,
    UPD_TICK
  } upd_t;

  function automatic logic bcd_valid(input digit_t d);
    return d <= MAX_DIGIT;
  endfunction

  // Two BCD digits combined as a binary value; 7 bits covers up to 99.
  function automatic logic [6:0] bcd_pair_value(input digit_t tens, input digit_t units);
    return 7'(tens) * 7'd10 + 7'(units);
  endfunction

  function automatic logic time_valid(input bcd_time_t t);
    return bcd_valid(t.ms_hr) && bcd_valid(t.ls_hr) &&
           bcd_valid(t.ms_min) && bcd_valid(t.ls_min) &&
           (t.ms_min <= MAX_MIN_TENS) &&
           (bcd_pair_value(t.ms_hr, t.ls_hr) <= 7'(MAX_HOUR));
  endfunction

endpackage

// File: rtl/aclk_bcd_digit.sv
// One BCD digit counter: synchronous load, increment modulo (limit+1), and a
// carry that is high in the cycle the digit wraps from limit back to 0.
module aclk_bcd_digit
  import aclk_pkg::*;
#(
  parameter digit_t INIT = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic [3:0] limit,
  output logic [3:0] q,
  output logic       carry
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= INIT;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= (q == limit) ? '0 : q + 4'd1;
    end
  end

  assign carry = inc && (q == limit);

endmodule

// File: rtl/aclk_time_counter.sv
// 24-hour BCD current-time register with validated load and minute advance.
// Define ACLK_AMPM_EN to present the hour in 12-hour format with a pm flag.
module aclk_time_counter
  import aclk_pkg::*;
#(
  parameter int unsigned INIT_HOUR = 0,
  parameter int unsigned INIT_MIN  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       load_new_c,
  input  logic [3:0] new_current_time_ms_hr,
  input  logic [3:0] new_current_time_ls_hr,
  input  logic [3:0] new_current_time_ms_min,
  input  logic [3:0] new_current_time_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic       pm,
  output logic       day_wrap,
  output logic       load_err
);

  bcd_time_t new_time;
  bcd_time_t cur;
  upd_t      upd;
  logic      do_load;
  logic      do_tick;
  logic      carry_ls_min;
  logic      carry_ms_min;
  logic      carry_ls_hr;
  logic      carry_ms_hr;
  digit_t    ls_hr_limit;

  assign new_time = '{ms_hr:  new_current_time_ms_hr,
                      ls_hr:  new_current_time_ls_hr,
                      ms_min: new_current_time_ms_min,
                      ls_min: new_current_time_ls_min};

  // A load request always wins the cycle, so a coincident minute pulse is lost.
  always_comb begin
    upd = UPD_IDLE;
    if (load_new_c) begin
      upd = time_valid(new_time) ? UPD_LOAD : UPD_REJECT;
    end else if (one_minute) begin
      upd = UPD_TICK;
    end
  end

  assign do_load = (upd == UPD_LOAD);
  assign do_tick = (upd == UPD_TICK);

  // Hour units wrap at 3 in the twenties so 23 rolls straight to 00.
  assign ls_hr_limit = (cur.ms_hr == MAX_HR_TENS) ? MAX_HR_UNITS_AT_20 : MAX_DIGIT;

  aclk_bcd_digit #(.INIT(digit_t'(INIT_MIN % 10))) u_ls_min (
    .clk      (clk),
    .reset    (reset),
    .inc      (do_tick),
    .load     (do_load),
    .load_val (new_time.ls_min),
    .limit    (MAX_DIGIT),
    .q        (cur.ls_min),
    .carry    (carry_ls_min)
  );

  aclk_bcd_digit #(.INIT(digit_t'(INIT_MIN / 10))) u_ms_min (
    .clk      (clk),
    .reset    (reset),
    .inc      (carry_ls_min),
    .load     (do_load),
    .load_val (new_time.ms_min),
    .limit    (MAX_MIN_TENS),
    .q        (cur.ms_min),
    .carry    (carry_ms_min)
  );

  aclk_bcd_digit #(.INIT(digit_t'(INIT_HOUR % 10))) u_ls_hr (
    .clk      (clk),
    .reset    (reset),
    .inc      (carry_ms_min),
    .load     (do_load),
    .load_val (new_time.ls_hr),
    .limit    (ls_hr_limit),
    .q        (cur.ls_hr),
    .carry    (carry_ls_hr)
  );

  aclk_bcd_digit #(.INIT(digit_t'(INIT_HOUR / 10))) u_ms_hr (
    .clk      (clk),
    .reset    (reset),
    .inc      (carry_ls_hr),
    .load     (do_load),
    .load_val (new_time.ms_hr),
    .limit    (MAX_HR_TENS),
    .q        (cur.ms_hr),
    .carry    (carry_ms_hr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      day_wrap <= carry_ms_hr;
      load_err <= (upd == UPD_REJECT);
    end
  end

  assign current_time_ms_min = cur.ms_min;
  assign current_time_ls_min = cur.ls_min;

`ifdef ACLK_AMPM_EN
  logic [4:0] hour24;
  logic [4:0] hour12;

  always_comb begin
    hour24 = 5'(cur.ms_hr) * 5'd10 + 5'(cur.ls_hr);
    pm     = (hour24 >= 5'd12);
    if (hour24 == 5'd0) begin
      hour12 = 5'd12;
    end else if (hour24 > 5'd12) begin
      hour12 = hour24 - 5'd12;
    end else begin
      hour12 = hour24;
    end
    if (hour12 >= 5'd10) begin
      current_time_ms_hr = 4'd1;
      current_time_ls_hr = 4'(hour12 - 5'd10);
    end else begin
      current_time_ms_hr = 4'd0;
      current_time_ls_hr = 4'(hour12);
    end
  end
`else
  assign current_time_ms_hr = cur.ms_hr;
  assign current_time_ls_hr = cur.ls_hr;
  assign pm                 = 1'b0;
`endif

endmodule

// File: tb/tb_aclk_time_counter.sv
// Self-checking bench for aclk_time_counter: directed scenarios plus random
// traffic against a minutes-of-day reference model.
module tb_aclk_time_counter;

  localparam int INIT_H = 7;
  localparam int INIT_M = 30;
  localparam int INIT_T = INIT_H * 60 + INIT_M;

  logic       clk = 1'b0;
  logic       reset;
  logic       one_minute;
  logic       load_new_c;
  logic [3:0] n_ms_hr, n_ls_hr, n_ms_min, n_ls_min;
  logic [3:0] c_ms_hr, c_ls_hr, c_ms_min, c_ls_min;
  logic       pm, day_wrap, load_err;

  int tests = 0;
  int fails = 0;

  // Reference state: minutes since midnight plus the two pulse flags.
  int   m_t  = INIT_T;
  logic m_dw = 1'b0;
  logic m_le = 1'b0;

  aclk_time_counter #(.INIT_HOUR(INIT_H), .INIT_MIN(INIT_M)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .one_minute              (one_minute),
    .load_new_c              (load_new_c),
    .new_current_time_ms_hr  (n_ms_hr),
    .new_current_time_ls_hr  (n_ls_hr),
    .new_current_time_ms_min (n_ms_min),
    .new_current_time_ls_min (n_ls_min),
    .current_time_ms_hr      (c_ms_hr),
    .current_time_ls_hr      (c_ls_hr),
    .current_time_ms_min     (c_ms_min),
    .current_time_ls_min     (c_ls_min),
    .pm                      (pm),
    .day_wrap                (day_wrap),
    .load_err                (load_err)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int h, m;
    if (!reset) begin
      m_t = INIT_T; m_dw = 0; m_le = 0;
    end else if (load_new_c) begin
      m_dw = 0;
      h = int'(n_ms_hr) * 10 + int'(n_ls_hr);
      m = int'(n_ms_min) * 10 + int'(n_ls_min);
      if (n_ms_hr <= 9 && n_ls_hr <= 9 && n_ms_min <= 5 && n_ls_min <= 9 && h <= 23) begin
        m_t = h * 60 + m; m_le = 0;
      end else begin
        m_le = 1;
      end
    end else if (one_minute) begin
      m_dw = (m_t == 1439);
      m_t  = (m_t + 1) % 1440;
      m_le = 0;
    end else begin
      m_dw = 0; m_le = 0;
    end
  endtask

  task automatic check(input string tag);
    int h, m;
    logic [15:0] exp_t, got_t;
    logic exp_pm;
    h = m_t / 60;
    m = m_t % 60;
`ifdef ACLK_AMPM_EN
    exp_pm = (h >= 12);
    if (h == 0) h = 12;
    else if (h > 12) h = h - 12;
`else
    exp_pm = 1'b0;
`endif
    exp_t = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    got_t = {c_ms_hr, c_ls_hr, c_ms_min, c_ls_min};
    tests++;
    assert (got_t === exp_t) else begin
      fails++;
      $error("FAIL %s time: got %h expected %h", tag, got_t, exp_t);
    end
    tests++;
    assert (pm === exp_pm) else begin
      fails++;
      $error("FAIL %s pm: got %b expected %b", tag, pm, exp_pm);
    end
    tests++;
    assert (day_wrap === m_dw) else begin
      fails++;
      $error("FAIL %s day_wrap: got %b expected %b", tag, day_wrap, m_dw);
    end
    tests++;
    assert (load_err === m_le) else begin
      fails++;
      $error("FAIL %s load_err: got %b expected %b", tag, load_err, m_le);
    end
  endtask

  // Inputs are held across the edge; the model sees the same values the DUT samples.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
    one_minute = 0;
    load_new_c = 0;
  endtask

  task automatic set_load(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    load_new_c = 1;
    n_ms_hr = a; n_ls_hr = b; n_ms_min = c; n_ls_min = d;
  endtask

  initial begin
    reset = 0; one_minute = 0; load_new_c = 0;
    n_ms_hr = 0; n_ls_hr = 0; n_ms_min = 0; n_ls_min = 0;

    // Reset holds INIT time even with activity on the inputs.
    cycle("reset0");
    one_minute = 1;
    cycle("reset_pulse");
    set_load(4'd1, 4'd2, 4'd3, 4'd4);
    cycle("reset_load");
    reset = 1;

    set_load(4'd1, 4'd2, 4'd5, 4'd9);
    cycle("load_1259");
    one_minute = 1;
    cycle("tick_1300");

    set_load(4'd2, 4'd3, 4'd5, 4'd9);
    cycle("load_2359");
    one_minute = 1;
    cycle("midnight");
    cycle("wrap_clear");

    set_load(4'd2, 4'd4, 4'd0, 4'd0);
    cycle("bad_2400");
    cycle("err_clear");
    set_load(4'd0, 4'd9, 4'd6, 4'hA);
    cycle("bad_096A");
    cycle("err_clear2");

    set_load(4'd1, 4'd8, 4'd4, 4'd5);
    one_minute = 1;
    cycle("load_drop");
    one_minute = 1;
    cycle("tick_1846");

    set_load(4'd1, 4'd0, 4'd1, 4'd7);
    cycle("load_1017");
    for (int i = 0; i < 60; i++) begin
      one_minute = 1;
      cycle("fast");
    end
    one_minute = 1;
    cycle("fast_more");
    one_minute = 1;
    reset = 0;
    cycle("reset_mid");
    reset = 1;

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      one_minute = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1)
          set_load(4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                   4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)));
        else
          set_load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      // Occasionally park near midnight so the wrap path gets exercised.
      if ($urandom_range(0, 99) == 0) set_load(4'd2, 4'd3, 4'd5, 4'd8);
      cycle("random");
    end
    reset = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
